serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fa.sv | 28 ++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/fa.sv
// Combinational full adder built from two half adders and an OR for the carry.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a(a),
    .b(b),
    .s(s0),
    .c(c0)
  );

  half_adder u_ha1 (
    .a(s0),
    .b(cin),
    .s(sum),
    .c(c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage consumes one operand bit per cycle, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_sum, fa_cout;

  fa u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // The carry flop holds the final carry from DONE until the next accepted start.
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: per-cycle reference model plus directed and random runs.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: cycles elapsed since the accepting edge, and the arithmetic result.
  int         phase;     // -1 when idle, else edges since accept
  logic [W:0] pend;
  logic [W:0] exp_res;
  logic       res_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= -1;
      exp_res   <= '0;
      res_valid <= 1'b1;
    end else if (phase < 0) begin
      if (start) begin
        phase     <= 0;
        pend      <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
        res_valid <= 1'b0;
      end
    end else if (phase == W) begin
      phase <= -1;
    end else begin
      phase <= phase + 1;
      if (phase + 1 == W) begin
        exp_res   <= pend;
        res_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy", 32'(busy), 32'(phase >= 0));
      check("done", 32'(done), 32'(phase == W));
      if (res_valid) check("result", 32'({cout, sum}), 32'(exp_res));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 40);
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles, required a pulse", n);
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W:0] expect_res);
    int n;
    @(posedge clk);
    #1;
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check({nm, "_latency"}, 32'(n), 32'(W + 1));
    check({nm, "_sum"}, 32'(sum), 32'(expect_res[W-1:0]));
    check({nm, "_cout"}, 32'(cout), 32'(expect_res[W]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    // start high during reset must not be taken at the release edge
    start = 1'b1; a = 8'd1; b = 8'd1;
    repeat (2) @(posedge clk);
    #3;
    start = 1'b0;
    rst_n = 1'b1;

    run_op("add_3_5", 8'd3, 8'd5, 1'b0, 9'd8);
    run_op("add_255_1", 8'd255, 8'd1, 1'b0, 9'h100);
    run_op("add_cin", 8'd0, 8'd0, 1'b1, 9'd1);
    run_op("add_max", 8'd255, 8'd255, 1'b1, 9'h1ff);

    // Restart attempt during SHIFT must be ignored
    @(posedge clk);
    #1;
    start = 1'b1; a = 8'd10; b = 8'd20; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd100;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ignore_latency", 32'(n + 3), 32'(W + 1));
    check("ignore_sum", 32'(sum), 32'd30);
    check("ignore_cout", 32'(cout), 32'd0);

    // Reset three cycles into SHIFT aborts with no done pulse
    @(posedge clk);
    #1;
    start = 1'b1; a = 8'd255; b = 8'd255; cin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    run_op("after_abort", 8'd7, 8'd9, 1'b1, 9'd17);

    // start held high: back-to-back operations separated by one IDLE cycle
    @(posedge clk);
    #1;
    start = 1'b1; a = 8'd200; b = 8'd100; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_done(n);
      check("held_period", 32'(n), 32'(W + 2));
      check("held_sum", 32'(sum), 32'd44);
      check("held_cout", 32'(cout), 32'd1);
    end
    start = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op("rand", ra, rb, rc, (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
